// File: rtl/alu4_reg.sv
// ---------------------------------------------------------------------------
// alu4_reg
//   Registered WIDTH-bit arithmetic/logic unit. The result word and a
//   signed-overflow flag are computed combinationally from A, B and Op and
//   captured on every rising clk edge. This gives one cycle of latency and
//   one operation per cycle, with no enable and no handshake.
//
// Ports
//   clk       in   1      rising-edge clock
//   rst_n     in   1      asynchronous active-low reset, clears both outputs
//   A         in   WIDTH  operand A (two's complement for ADD/SUB/SHL flag)
//   B         in   WIDTH  operand B (ignored by NOT/SHL/SHR)
//   Op        in   3      operation select
//                           000 ADD, 001 SUB, 010 AND, 011 OR,
//                           100 XOR, 101 NOT, 110 SHL, 111 SHR
//   ALU_out   out  WIDTH  registered result
//   overflow  out  1      registered signed-overflow flag
// ---------------------------------------------------------------------------
module alu4_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Op,
    output logic [WIDTH-1:0] ALU_out,
    output logic             overflow
);

    localparam int MSB = WIDTH - 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] result_d;
    logic             ovf_d;
    logic [WIDTH-1:0] result_q;
    logic             ovf_q;

    // Both are truncated to WIDTH bits, so carry and borrow out are dropped.
    assign sum  = A + B;
    assign diff = A - B;

    always_comb begin
        result_d = '0;
        ovf_d    = 1'b0;
        case (Op)
            OP_ADD: begin
                result_d = sum;
                // The operands have the same sign but the result has the other sign.
                ovf_d    = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
            end
            OP_SUB: begin
                result_d = diff;
                // The operands have different signs and the result's sign differs from A's.
                ovf_d    = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
            end
            OP_AND: result_d = A & B;
            OP_OR:  result_d = A | B;
            OP_XOR: result_d = A ^ B;
            OP_NOT: result_d = ~A;
            OP_SHL: begin
                result_d = {A[MSB-1:0], 1'b0};
                // Doubling changes the sign when the top two bits of A differ.
                ovf_d    = A[MSB] ^ A[MSB-1];
            end
            OP_SHR: result_d = {1'b0, A[MSB:1]};
            default: begin
                result_d = '0;
                ovf_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            result_q <= result_d;
            ovf_q    <= ovf_d;
        end
    end

    assign ALU_out  = result_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_alu4_reg.sv
module tb_alu4_reg;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] Op;
    logic [3:0] ALU_out;
    logic       overflow;

    int total;
    int bad;

    alu4_reg #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (A),
        .B        (B),
        .Op       (Op),
        .ALU_out  (ALU_out),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_r;
        logic       exp_v;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the arithmetic is done on signed integers, and overflow is a range check.
    function automatic logic [4:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int sa;
        int sb;
        int s;
        logic [3:0] r;
        logic v;
        sa = (a > 4'd7) ? int'(a) - 16 : int'(a);
        sb = (b > 4'd7) ? int'(b) - 16 : int'(b);
        v = 1'b0;
        r = 4'd0;
        case (op)
            3'd0: begin s = sa + sb; r = 4'(s); v = (s > 7) || (s < -8); end
            3'd1: begin s = sa - sb; r = 4'(s); v = (s > 7) || (s < -8); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = 4'(15 - int'(a));
            3'd6: begin s = sa * 2; r = 4'(s); v = (s > 7) || (s < -8); end
            default: r = 4'(int'(a) / 2);
        endcase
        return {v, r};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [4:0] prev;
        logic [4:0] exp;

        total = 0;
        bad   = 0;

        vecs[0]  = '{"add_ovf",   3'b000, 4'b0111, 4'b0001, 4'b1000, 1'b1};
        vecs[1]  = '{"add_wrap",  3'b000, 4'b1111, 4'b0001, 4'b0000, 1'b0};
        vecs[2]  = '{"sub_ovf",   3'b001, 4'b1000, 4'b0001, 4'b0111, 1'b1};
        vecs[3]  = '{"sub_neg",   3'b001, 4'b0011, 4'b0101, 4'b1110, 1'b0};
        vecs[4]  = '{"and",       3'b010, 4'b1100, 4'b1010, 4'b1000, 1'b0};
        vecs[5]  = '{"or",        3'b011, 4'b1100, 4'b1010, 4'b1110, 1'b0};
        vecs[6]  = '{"xor",       3'b100, 4'b1100, 4'b1010, 4'b0110, 1'b0};
        vecs[7]  = '{"not",       3'b101, 4'b1100, 4'b1010, 4'b0011, 1'b0};
        vecs[8]  = '{"shl",       3'b110, 4'b0100, 4'b0000, 4'b1000, 1'b1};
        vecs[9]  = '{"shl_b1111", 3'b110, 4'b0100, 4'b1111, 4'b1000, 1'b1};
        vecs[10] = '{"shr",       3'b111, 4'b1001, 4'b0000, 4'b0100, 1'b0};
        vecs[11] = '{"shr_b1111", 3'b111, 4'b1001, 4'b1111, 4'b0100, 1'b0};

        // Assert reset between clock edges. The outputs must clear without an edge.
        rst_n = 1'b1;
        A = 4'b0111; B = 4'b0001; Op = 3'b000;
        #2 rst_n = 1'b0;
        #1 check("reset_async", {overflow, ALU_out}, 5'b0_0000);
        repeat (2) @(posedge clk);
        #1 check("reset_hold", {overflow, ALU_out}, 5'b0_0000);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            A = vecs[i].a; B = vecs[i].b; Op = vecs[i].op;
            @(posedge clk);
            #1;
            check({vecs[i].name, "_r"}, {1'b0, ALU_out}, {1'b0, vecs[i].exp_r});
            check({vecs[i].name, "_v"}, {4'b0, overflow}, {4'b0, vecs[i].exp_v});
        end

        // Assert reset in mid-stream with a nonzero result held in the register.
        A = 4'b0111; B = 4'b0001; Op = 3'b000;
        @(posedge clk);
        #1 check("pre_reset", {overflow, ALU_out}, 5'b1_1000);
        #2 rst_n = 1'b0;
        #1 check("mid_reset_async", {overflow, ALU_out}, 5'b0_0000);
        A = 4'b1100; B = 4'b1010; Op = 3'b011;
        repeat (2) @(posedge clk);
        #1 check("mid_reset_hold", {overflow, ALU_out}, 5'b0_0000);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1 check("first_after_release", {overflow, ALU_out}, 5'b0_1110);

        // Back-to-back random ops. Just before each edge the previous result must still be held.
        prev = {overflow, ALU_out};
        for (int n = 0; n < 30; n++) begin
            A  = 4'($urandom_range(0, 15));
            B  = 4'($urandom_range(0, 15));
            Op = 3'($urandom_range(0, 7));
            exp = model(Op, A, B);
            #1 check("rand_latency", {overflow, ALU_out}, prev);
            @(posedge clk);
            #1 check("rand_result", {overflow, ALU_out}, exp);
            prev = exp;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
